// File: rtl/calc_entry_seq_if.sv
// Key-decoder / ALU / display bundle for the calculator entry sequencer.
// master = stimulus side (keys, ALU results); slave = the sequencer itself.
interface calc_entry_seq_if #(
  parameter int DIGITS = 4,
  parameter int OPW    = 2
);
  localparam int W = 4 * DIGITS;

  logic           key_valid;
  logic           is_num;
  logic           is_op;
  logic           is_eq;
  logic           is_clr;
  logic [3:0]     num_val;
  logic [OPW-1:0] op_val;
  logic [W-1:0]   alu_result;
  logic           alu_err;
  logic           alu_done;
  logic           alu_start;
  logic [W-1:0]   num1_bcd;
  logic [W-1:0]   num2_bcd;
  logic [OPW-1:0] operation;
  logic [2:0]     curr_state;
  logic           disp_sel;
  logic           error;

  modport master (
    output key_valid, is_num, is_op, is_eq, is_clr,
    output num_val, op_val,
    output alu_result, alu_err, alu_done,
    input  alu_start, num1_bcd, num2_bcd, operation,
    input  curr_state, disp_sel, error
  );

  modport slave (
    input  key_valid, is_num, is_op, is_eq, is_clr,
    input  num_val, op_val,
    input  alu_result, alu_err, alu_done,
    output alu_start, num1_bcd, num2_bcd, operation,
    output curr_state, disp_sel, error
  );
endinterface

// File: rtl/calc_entry_seq.sv
// Keypad entry sequencer N1 -> OP -> N2 -> CALC -> RES/ERR; packs BCD operands
// and runs the ALU start/done handshake. Ports: clk, rst (sync, high), bus (slave).
module calc_entry_seq #(
  parameter int DIGITS = 4,
  parameter int OPW    = 2
) (
  input logic              clk,
  input logic              rst,
  calc_entry_seq_if.slave  bus
);
  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);

  typedef enum logic [2:0] {
    S_N1   = 3'd0,
    S_OP   = 3'd1,
    S_N2   = 3'd2,
    S_CALC = 3'd3,
    S_RES  = 3'd4,
    S_ERR  = 3'd5
  } state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   num1_q, num1_d;
  logic [W-1:0]   num2_q, num2_d;
  logic [OPW-1:0] op_q, op_d;
  logic [OPW-1:0] pend_q, pend_d;
  logic [CW-1:0]  cnt1_q, cnt1_d;
  logic [CW-1:0]  cnt2_q, cnt2_d;
  logic           chain_q, chain_d;
  logic           start_q, start_d;

  logic k_clr, k_eq, k_op, k_num;
  logic [W-1:0] dig;

  // clr > eq > op > num; non-BCD digits are dropped
  assign k_clr = bus.key_valid & bus.is_clr;
  assign k_eq  = bus.key_valid & bus.is_eq & ~bus.is_clr;
  assign k_op  = bus.key_valid & bus.is_op & ~bus.is_clr & ~bus.is_eq;
  assign k_num = bus.key_valid & bus.is_num & ~bus.is_clr
               & ~bus.is_eq & ~bus.is_op & (bus.num_val <= 4'd9);
  assign dig   = W'(bus.num_val);

  always_comb begin
    state_d = state_q;
    num1_d  = num1_q;
    num2_d  = num2_q;
    op_d    = op_q;
    pend_d  = pend_q;
    cnt1_d  = cnt1_q;
    cnt2_d  = cnt2_q;
    chain_d = chain_q;
    case (state_q)
      S_N1: begin
        if (k_op) begin
          op_d    = bus.op_val;
          state_d = S_OP;
        end else if (k_num && cnt1_q < CW'(DIGITS)) begin
          num1_d = (num1_q << 4) | dig;
          cnt1_d = cnt1_q + CW'(1);
        end
      end
      S_OP: begin
        if (k_op) begin
          op_d = bus.op_val;
        end else if (k_num) begin
          num2_d  = dig;
          cnt2_d  = CW'(1);
          state_d = S_N2;
        end
      end
      S_N2: begin
        if (k_eq) begin
          chain_d = 1'b0;
          state_d = S_CALC;
        end else if (k_op) begin
          pend_d  = bus.op_val;
          chain_d = 1'b1;
          state_d = S_CALC;
        end else if (k_num && cnt2_q < CW'(DIGITS)) begin
          num2_d = (num2_q << 4) | dig;
          cnt2_d = cnt2_q + CW'(1);
        end
      end
      S_CALC: begin
        if (bus.alu_done) begin
          if (bus.alu_err) begin
            state_d = S_ERR;
          end else begin
            num1_d = bus.alu_result;
            // result is not editable: block further digit appends
            cnt1_d = CW'(DIGITS);
            if (chain_q) begin
              op_d    = pend_q;
              num2_d  = '0;
              cnt2_d  = '0;
              state_d = S_OP;
            end else begin
              state_d = S_RES;
            end
          end
        end
      end
      S_RES: begin
        if (k_eq) begin
          chain_d = 1'b0;
          state_d = S_CALC;
        end else if (k_op) begin
          op_d    = bus.op_val;
          state_d = S_OP;
        end else if (k_num) begin
          num1_d  = dig;
          cnt1_d  = CW'(1);
          num2_d  = '0;
          op_d    = '0;
          state_d = S_N1;
        end
      end
      S_ERR: ;
      default: state_d = S_N1;
    endcase
    if (k_clr) begin
      state_d = S_N1;
      num1_d  = '0;
      num2_d  = '0;
      op_d    = '0;
      pend_d  = '0;
      cnt1_d  = '0;
      cnt2_d  = '0;
      chain_d = 1'b0;
    end
  end

  // pulse only on the edge into CALC
  assign start_d = (state_d == S_CALC) && (state_q != S_CALC);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_N1;
      num1_q  <= '0;
      num2_q  <= '0;
      op_q    <= '0;
      pend_q  <= '0;
      cnt1_q  <= '0;
      cnt2_q  <= '0;
      chain_q <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      num1_q  <= num1_d;
      num2_q  <= num2_d;
      op_q    <= op_d;
      pend_q  <= pend_d;
      cnt1_q  <= cnt1_d;
      cnt2_q  <= cnt2_d;
      chain_q <= chain_d;
      start_q <= start_d;
    end
  end

  assign bus.alu_start  = start_q;
  assign bus.num1_bcd   = num1_q;
  assign bus.num2_bcd   = num2_q;
  assign bus.operation  = op_q;
  assign bus.curr_state = state_q;
  assign bus.disp_sel   = (state_q == S_N2);
  assign bus.error      = (state_q == S_ERR);
endmodule

// File: tb/tb_calc_entry_seq.sv
// Scoreboard bench for calc_entry_seq: operand snapshots expected at each
// alu_start are queued when keys are pressed; a small ALU model answers.
module tb_calc_entry_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  calc_entry_seq_if #(.DIGITS(4), .OPW(2)) bus ();

  calc_entry_seq #(.DIGITS(4), .OPW(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  localparam logic [1:0] ADD = 2'd0;
  localparam logic [1:0] SUB = 2'd1;
  localparam logic [1:0] DIV = 2'd3;

  int tests = 0;
  int fails = 0;
  logic [33:0] sb[$];

  int          alu_lat = 0;
  logic [15:0] alu_res = '0;
  logic        alu_erv = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic key(input logic n, input logic o, input logic e,
                     input logic c, input logic [3:0] nv,
                     input logic [1:0] ov);
    @(negedge clk);
    bus.key_valid = 1'b1;
    bus.is_num = n;
    bus.is_op  = o;
    bus.is_eq  = e;
    bus.is_clr = c;
    bus.num_val = nv;
    bus.op_val  = ov;
    @(negedge clk);
    bus.key_valid = 1'b0;
    bus.is_num = 1'b0;
    bus.is_op  = 1'b0;
    bus.is_eq  = 1'b0;
    bus.is_clr = 1'b0;
  endtask

  task automatic dg(input logic [3:0] d);
    key(1'b1, 1'b0, 1'b0, 1'b0, d, 2'd0);
  endtask
  task automatic op(input logic [1:0] o);
    key(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, o);
  endtask
  task automatic eq();
    key(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 2'd0);
  endtask
  task automatic clr();
    key(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 2'd0);
  endtask

  task automatic wait_st(input string tag, input logic [2:0] s);
    for (int i = 0; i < 50; i++) begin
      if (bus.curr_state == s) break;
      @(negedge clk);
    end
    chk(tag, bus.curr_state, s);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_st"}, bus.curr_state, 3'd0);
    chk({tag, "_all"},
        {bus.num1_bcd, bus.num2_bcd, bus.operation,
         bus.alu_start, bus.disp_sel, bus.error}, '0);
  endtask

  // ALU model: answers each alu_start after alu_lat cycles
  initial begin
    bus.alu_done = 1'b0;
    bus.alu_err = 1'b0;
    bus.alu_result = '0;
    forever begin
      @(negedge clk);
      if (bus.alu_start === 1'b1) begin
        repeat (alu_lat) @(negedge clk);
        bus.alu_result = alu_res;
        bus.alu_err = alu_erv;
        bus.alu_done = 1'b1;
        @(negedge clk);
        bus.alu_done = 1'b0;
        bus.alu_err = 1'b0;
      end
    end
  end

  // every alu_start cycle must match the oldest queued operand snapshot
  always @(negedge clk) begin
    if (bus.alu_start === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_start", 1, 0);
      end else begin
        chk("start_operands",
            {bus.num1_bcd, bus.num2_bcd, bus.operation}, sb.pop_front());
      end
    end
  end

  initial begin
    bus.key_valid = 1'b0;
    bus.is_num = 1'b0;
    bus.is_op  = 1'b0;
    bus.is_eq  = 1'b0;
    bus.is_clr = 1'b0;
    bus.num_val = '0;
    bus.op_val  = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_zero("reset");

    // saturation at 4 digits
    dg(1); dg(2); dg(3); dg(4); dg(5);
    chk("sat_num1", bus.num1_bcd, 16'h1234);
    chk("sat_state", bus.curr_state, 3'd0);
    // invalid digit and flag priority
    dg(4'hA);
    chk("bad_digit", bus.num1_bcd, 16'h1234);
    key(1'b1, 1'b0, 1'b0, 1'b1, 4'd7, 2'd0);
    chk_zero("clr_prio");

    // 12 + 3 = 15
    dg(1); dg(2); op(ADD);
    chk("op_state", bus.curr_state, 3'd1);
    dg(3);
    chk("n2_state", {bus.curr_state, bus.disp_sel, bus.num2_bcd},
        {3'd2, 1'b1, 16'h0003});
    alu_lat = 2; alu_res = 16'h0015; alu_erv = 1'b0;
    sb.push_back({16'h0012, 16'h0003, ADD});
    eq();
    wait_st("res_wait", 3'd4);
    chk("res_num1", {bus.num1_bcd, bus.disp_sel}, {16'h0015, 1'b0});

    // 2 + 3 = 5, then repeated '=' -> 8
    clr();
    dg(2); op(ADD); dg(3);
    alu_lat = 0; alu_res = 16'h0005;
    sb.push_back({16'h0002, 16'h0003, ADD});
    eq();
    wait_st("res1_wait", 3'd4);
    alu_lat = 1; alu_res = 16'h0008;
    sb.push_back({16'h0005, 16'h0003, ADD});
    eq();
    chk("calc_state", bus.curr_state, 3'd3);
    wait_st("res2_wait", 3'd4);
    chk("rep_eq_num1", bus.num1_bcd, 16'h0008);
    // digit in RES starts a fresh entry
    dg(7); dg(8);
    chk("res_digit", {bus.curr_state, bus.num1_bcd, bus.num2_bcd,
                      bus.operation}, {3'd0, 16'h0078, 16'h0, 2'd0});

    // chained: 5 + 3 - 4 =
    clr();
    dg(5); op(ADD); dg(3);
    alu_lat = 1; alu_res = 16'h0008;
    sb.push_back({16'h0005, 16'h0003, ADD});
    op(SUB);
    chk("chain_calc", bus.curr_state, 3'd3);
    wait_st("chain_wait", 3'd1);
    chk("chain_regs", {bus.num1_bcd, bus.num2_bcd, bus.operation},
        {16'h0008, 16'h0, SUB});
    dg(4);
    alu_res = 16'h0004;
    sb.push_back({16'h0008, 16'h0004, SUB});
    eq();
    wait_st("chain_res", 3'd4);
    chk("chain_num1", bus.num1_bcd, 16'h0004);

    // error path: 9 / 5 with alu_err
    clr();
    dg(9); op(DIV); dg(5);
    alu_lat = 1; alu_res = 16'h0000; alu_erv = 1'b1;
    sb.push_back({16'h0009, 16'h0005, DIV});
    eq();
    wait_st("err_wait", 3'd5);
    alu_erv = 1'b0;
    chk("err_regs", {bus.error, bus.num1_bcd, bus.num2_bcd},
        {1'b1, 16'h0009, 16'h0005});
    dg(3); op(ADD); eq();
    chk("err_hold", {bus.curr_state, bus.error, bus.num1_bcd,
                     bus.alu_start}, {3'd5, 1'b1, 16'h0009, 1'b0});
    clr();
    chk_zero("err_clr");

    // op beats num in the same key
    dg(6);
    key(1'b1, 1'b1, 1'b0, 1'b0, 4'd2, SUB);
    chk("op_prio", {bus.curr_state, bus.num1_bcd, bus.operation},
        {3'd1, 16'h0006, SUB});

    // clr during CALC; the late alu_done must be ignored
    clr();
    dg(6); op(ADD); dg(1);
    alu_lat = 2; alu_res = 16'h0007;
    sb.push_back({16'h0006, 16'h0001, ADD});
    eq();
    clr();
    chk_zero("calc_clr");
    repeat (3) @(negedge clk);
    chk_zero("calc_clr_late");

    // synchronous reset mid-N2
    dg(1); op(ADD); dg(2);
    chk("pre_rst", bus.curr_state, 3'd2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_zero("rst_n2");

    repeat (4) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
